fpu_addsub_issue_ctrl: RTL

//  Issue controller and arbiter for the fixed-latency pipelined FP add/sub datapath (single precision).

---
 rtl/fpu_addsub_pkg.sv | 26 ++
 rtl/fpu_rsp_fifo.sv | 62 ++++++
 rtl/fpu_addsub_issue_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fpu_addsub_pkg.sv
// Shared types and constants for the FP add/sub issue controller.
//   DATA_SIZE      operand/result width (IEEE-754 single)
//   TAG_W          requester tag width, carried through untouched
//   rsp_entry_t    one response FIFO entry {result, ovf, id, tag}
//   trk_entry_t    one in-flight tracker slot {valid, id, tag}
package fpu_addsub_pkg;

   localparam int EXPONENT_SIZE = 8;
   localparam int FRACTION_SIZE = 23;
   localparam int DATA_SIZE     = 1 + EXPONENT_SIZE + FRACTION_SIZE;
   localparam int TAG_W         = 4;

   typedef struct packed {
      logic [DATA_SIZE-1:0] result;
      logic                 ovf;
      logic                 id;
      logic [TAG_W-1:0]     tag;
   } rsp_entry_t;

   typedef struct packed {
      logic             valid;
      logic             id;
      logic [TAG_W-1:0] tag;
   } trk_entry_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// First-word fall-through response FIFO.
//   clk, rst        clock, synchronous active-high reset (pointers only)
//   push, push_data write port; a push while full is taken only with a pop
//   pop             read strobe; ignored while empty
//   head_data       current head entry (valid while !empty)
//   empty           no entries stored
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fpu_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fpu_addsub_issue_ctrl.sv
// Issue controller for the shared, fixed-latency, non-stallable FP add/sub
// datapath. Two requesters are arbitrated round-robin; each issued op's
// {id, tag} rides a tracker aligned with the datapath, and results land in a
// credit-protected FWFT response FIFO.
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid/ready            N=0,1 request handshake (ready = grant)
//   reqN_a/_b/_sub/_tag         operands, 1=A-B, requester tag
//   pipe_in_valid/_a/_b/_sub    issue to datapath, combinational from grant
//   pipe_result, pipe_ovf       datapath output, PIPE_LATENCY after issue
//   rsp_valid/ready             response FIFO head handshake
//   rsp_result/_ovf/_id/_tag    response FIFO head contents
//   ovf_sticky, ovf_clr         per-requester overflow sticky bits
//                               (only with FPU_ADDSUB_OVF_STICKY_EN)
//   busy                        op in flight or FIFO non-empty
// Optional feature macro: FPU_ADDSUB_OVF_STICKY_EN
module fpu_addsub_issue_ctrl
   import fpu_addsub_pkg::*;
#(
   parameter int PIPE_LATENCY = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [DATA_SIZE-1:0] req0_a,
   input  logic [DATA_SIZE-1:0] req0_b,
   input  logic                 req0_sub,
   input  logic [TAG_W-1:0]     req0_tag,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [DATA_SIZE-1:0] req1_a,
   input  logic [DATA_SIZE-1:0] req1_b,
   input  logic                 req1_sub,
   input  logic [TAG_W-1:0]     req1_tag,
   output logic                 pipe_in_valid,
   output logic [DATA_SIZE-1:0] pipe_a,
   output logic [DATA_SIZE-1:0] pipe_b,
   output logic                 pipe_sub,
   input  logic [DATA_SIZE-1:0] pipe_result,
   input  logic                 pipe_ovf,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_SIZE-1:0] rsp_result,
   output logic                 rsp_ovf,
   output logic                 rsp_id,
   output logic [TAG_W-1:0]     rsp_tag,
`ifdef FPU_ADDSUB_OVF_STICKY_EN
   output logic [1:0]           ovf_sticky,
   input  logic [1:0]           ovf_clr,
`endif
   output logic                 busy
);

   localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;

   logic [CRED_W-1:0] credits_q, credits_d;
   logic              last_grant_q, last_grant_d;
   trk_entry_t        trk_q [PIPE_LATENCY];
   trk_entry_t        trk_d [PIPE_LATENCY];

   logic              credit_ok;
   logic              grant0, grant1;
   logic              issue;
   logic              pop;
   logic              push;
   logic              fifo_empty;
   logic              trk_any;
   rsp_entry_t        push_entry;
   rsp_entry_t        head_entry;

   // Credits cover both in-flight ops and FIFO entries, so a granted issue
   // always has a FIFO slot waiting when its result emerges.
   assign credit_ok = (credits_q != '0) && !rst;
   assign grant0    = credit_ok && req0_valid && (!req1_valid || last_grant_q);
   assign grant1    = credit_ok && req1_valid && (!req0_valid || !last_grant_q);
   assign issue     = grant0 || grant1;

   assign req0_ready    = grant0;
   assign req1_ready    = grant1;
   assign pipe_in_valid = issue;
   assign pipe_a        = grant0 ? req0_a   : (grant1 ? req1_a   : '0);
   assign pipe_b        = grant0 ? req0_b   : (grant1 ? req1_b   : '0);
   assign pipe_sub      = grant0 ? req0_sub : (grant1 ? req1_sub : 1'b0);

   assign push                = trk_q[PIPE_LATENCY-1].valid;
   assign push_entry.result   = pipe_result;
   assign push_entry.ovf      = pipe_ovf;
   assign push_entry.id       = trk_q[PIPE_LATENCY-1].id;
   assign push_entry.tag      = trk_q[PIPE_LATENCY-1].tag;

   assign rsp_valid  = !fifo_empty;
   assign pop        = rsp_valid && rsp_ready;
   assign rsp_result = head_entry.result;
   assign rsp_ovf    = head_entry.ovf;
   assign rsp_id     = head_entry.id;
   assign rsp_tag    = head_entry.tag;
   assign busy       = trk_any || !fifo_empty;

   fpu_rsp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(rsp_entry_t))
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_entry),
      .empty     (fifo_empty)
   );

   always_comb begin
      trk_any = 1'b0;
      for (int i = 0; i < PIPE_LATENCY; i++) begin
         trk_any = trk_any || trk_q[i].valid;
      end
   end

   always_comb begin
      trk_d[0].valid = issue;
      trk_d[0].id    = grant1;
      trk_d[0].tag   = grant1 ? req1_tag : req0_tag;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
         trk_d[i] = trk_q[i-1];
      end
   end

   always_comb begin
      credits_d = credits_q;
      unique case ({issue, pop})
         2'b10:   credits_d = credits_q - CRED_W'(1);
         2'b01:   credits_d = credits_q + CRED_W'(1);
         default: credits_d = credits_q;
      endcase
      last_grant_d = issue ? grant1 : last_grant_q;
   end

`ifdef FPU_ADDSUB_OVF_STICKY_EN
   logic [1:0] ovf_sticky_q, ovf_sticky_d;

   assign ovf_sticky = ovf_sticky_q;

   // Clear first, then set, so a set landing with a clear is kept.
   always_comb begin
      ovf_sticky_d = ovf_sticky_q & ~ovf_clr;
      if (push && pipe_ovf) begin
         ovf_sticky_d[push_entry.id] = 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         credits_q    <= CRED_W'(FIFO_DEPTH);
         last_grant_q <= 1'b1;
         for (int i = 0; i < PIPE_LATENCY; i++) begin
            trk_q[i] <= '0;
         end
`ifdef FPU_ADDSUB_OVF_STICKY_EN
         ovf_sticky_q <= 2'b00;
`endif
      end else begin
         credits_q    <= credits_d;
         last_grant_q <= last_grant_d;
         trk_q        <= trk_d;
`ifdef FPU_ADDSUB_OVF_STICKY_EN
         ovf_sticky_q <= ovf_sticky_d;
`endif
      end
   end

endmodule
